id_inst_buffer: RTL and testbench

- Parametrised instruction buffer between the fetch stage and the decode stage of the MiniMIPS32 pipeline.
- Decouples fetch from decode stalls (load-use hazards) using a DEPTH-entry FIFO of {pc, inst}.
- Performs the little-endian byte reorganisation before decode.
- Pre-decodes branch/jump opcodes to generate the delay-slot flag, and clears all entries on a pipeline flush.

---
 rtl/id_inst_buffer.sv | 111 +++++++++++
 tb/tb_id_inst_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/id_inst_buffer.sv
// Fetch-to-decode instruction FIFO with byte swap and delay-slot pre-decode.
// Optional ID_BYPASS_EN presents an incoming word to decode while the buffer is empty.
module id_inst_buffer #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int INST_W = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [INST_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    output logic              id_valid,
    output logic [INST_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_in_delay,
    input  logic              id_ready,
    output logic [PTR_W:0]    count
);

    logic [INST_W-1:0] r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_delay_pending;

    logic              w_empty;
    logic              w_full;
    logic              w_byp;
    logic              w_wr;
    logic              w_rd;
    logic              w_fire;
    logic              w_branch;
    logic [5:0]        w_op;
    logic [5:0]        w_func;
    logic [INST_W-1:0] w_head_pc;
    logic [INST_W-1:0] w_head_raw;
    logic [INST_W-1:0] w_head_swap;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));

`ifdef ID_BYPASS_EN
    assign w_byp = w_empty & if_valid & ~flush;
`else
    assign w_byp = 1'b0;
`endif

    assign w_head_pc   = w_byp ? if_pc   : r_pc_mem[r_rd_ptr];
    assign w_head_raw  = w_byp ? if_inst : r_inst_mem[r_rd_ptr];
    assign w_head_swap = {w_head_raw[7:0],   w_head_raw[15:8],
                          w_head_raw[23:16], w_head_raw[31:24]};

    assign if_ready    = ~w_full;
    assign id_valid    = ~w_empty | w_byp;
    assign id_pc       = id_valid ? w_head_pc   : '0;
    assign id_inst     = id_valid ? w_head_swap : '0;
    assign id_in_delay = id_valid & r_delay_pending;
    assign count       = r_count;

    // A bypassed word taken by decode in the same cycle never enters storage
    assign w_fire = id_valid & id_ready;
    assign w_rd   = w_fire & ~w_empty;
    assign w_wr   = if_valid & if_ready & ~(w_byp & id_ready);

    assign w_op   = w_head_swap[31:26];
    assign w_func = w_head_swap[5:0];

    always_comb begin
        w_branch = 1'b0;
        unique case (1'b1)
            (w_op == 6'b000000): w_branch = (w_func == 6'b001000);
            (w_op == 6'b000001),
            (w_op == 6'b000010),
            (w_op == 6'b000011),
            (w_op[5:2] == 4'b0001): w_branch = 1'b1;
            default: w_branch = 1'b0;
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (w_wr && !flush) begin
            r_pc_mem[r_wr_ptr]   <= if_pc;
            r_inst_mem[r_wr_ptr] <= if_inst;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_delay_pending <= 1'b0;
        end else if (flush) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_delay_pending <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_fire) r_delay_pending <= w_branch;
            if (w_wr && !w_rd) r_count <= r_count + 1'b1;
            else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: tb/tb_id_inst_buffer.sv
// Scoreboard bench for id_inst_buffer: expected decode words are queued
// by the stimulus and popped by a monitor on every accepted head.
module tb_id_inst_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_in_delay;
    logic        id_ready = 1'b0;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        dly;
    } exp_t;

    exp_t sb[$];

    id_inst_buffer #(.DEPTH(4), .PTR_W(2), .INST_W(32)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .flush       (flush),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_ready    (if_ready),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_in_delay (id_in_delay),
        .id_ready    (id_ready),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: every head that decode accepts must match the next queued entry
    always @(negedge clk) begin
        if (rst_n && !flush && id_valid && id_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", id_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_pc", id_pc, e.pc);
                chk("out_inst", id_inst, e.inst);
                chk("out_dly", {31'd0, id_in_delay}, {31'd0, e.dly});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] pc, input logic [31:0] raw);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = raw;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (count != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_done", {29'd0, count}, 32'd0);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_ready", {31'd0, if_ready}, 32'd1);
        chk("rst_inst", id_inst, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        rst_n = 1'b1;
        step();

        // single instruction, byte swap and latency
        id_ready = 1'b1;
        put(32'hBFC0_0000, 32'h3C01_1234);
        sb.push_back({32'hBFC0_0000, 32'h3412_013C, 1'b0});
        step();
        if_valid = 1'b0;
`ifdef ID_BYPASS_EN
        chk("lat_count", {29'd0, count}, 32'd0);
`else
        chk("lat_count", {29'd0, count}, 32'd1);
        chk("lat_valid", {31'd0, id_valid}, 32'd1);
        step();
        chk("lat_count0", {29'd0, count}, 32'd0);
`endif

        // fill to full while decode stalls
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            sb.push_back({32'h100 + 32'(i * 4), 8'h24, 16'h0, 8'(i), 1'b0});
        for (int i = 0; i < 4; i++) begin
            put(32'h100 + 32'(i * 4), {8'(i), 16'h0, 8'h24});
            step();
        end
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_ready", {31'd0, if_ready}, 32'd0);
        put(32'h110, {8'd4, 16'h0, 8'h24});
        step();
        chk("full_hold", {29'd0, count}, 32'd4);
        id_ready = 1'b1;
        chk("no_bypass_full", {31'd0, if_ready}, 32'd0);
        step();
        chk("after_deq", {29'd0, count}, 32'd3);
        step();
        chk("enq_deq", {29'd0, count}, 32'd3);
        if_valid = 1'b0;
        drain();

        // delay-slot flag: beq, addiu, ori
        put(32'h200, 32'h0300_2210);
        sb.push_back({32'h200, 32'h1022_0003, 1'b0});
        sb.push_back({32'h204, 32'h2421_0001, 1'b1});
        sb.push_back({32'h208, 32'h3421_0002, 1'b0});
        step();
        put(32'h204, 32'h0100_2124);
        step();
        put(32'h208, 32'h0200_2134);
        step();
        if_valid = 1'b0;
        drain();
        step();

        // flush with pending delay slot and concurrent enqueue
        put(32'h300, 32'h0300_2210);
        sb.push_back({32'h300, 32'h1022_0003, 1'b0});
        step();
        if_valid = 1'b0;
        step();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(32'h304 + 32'(i * 4), 32'h0100_2124);
            step();
        end
        chk("pre_flush_cnt", {29'd0, count}, 32'd3);
        chk("pre_flush_dly", {31'd0, id_in_delay}, 32'd1);
        flush = 1'b1;
        put(32'h3F0, 32'h0100_2124);
        step();
        flush = 1'b0;
        if_valid = 1'b0;
        chk("flush_count", {29'd0, count}, 32'd0);
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_dly", {31'd0, id_in_delay}, 32'd0);
        id_ready = 1'b1;
        put(32'h400, 32'h0200_2134);
        sb.push_back({32'h400, 32'h3421_0002, 1'b0});
        step();
        if_valid = 1'b0;
        drain();

        // asynchronous reset mid-stream
        id_ready = 1'b0;
        put(32'h500, 32'h0100_2124);
        step();
        put(32'h504, 32'h0100_2124);
        step();
        if_valid = 1'b0;
        chk("pre_rst_cnt", {29'd0, count}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_count", {29'd0, count}, 32'd0);
        chk("arst_ready", {31'd0, if_ready}, 32'd1);
        chk("arst_inst", id_inst, 32'd0);
        step();
        #2;
        rst_n = 1'b1;
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
